// File: rtl/imem_fetch_responder.sv
// Multi-cycle instruction memory for the fetch stage: returns the addressed word after
// LATENCY cycles, drives the fetch freeze, and has a preload port. Optional: IMEM_RANGE_CHECK_EN.

module imem_fetch_responder #(
  parameter int WORD_LENGTH = 32,
  parameter int DEPTH       = 256,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [31:0]            address,
  input  logic                   flush,
  input  logic                   load_en,
  input  logic [31:0]            load_addr,
  input  logic [WORD_LENGTH-1:0] load_data,
  output logic                   stall,
  output logic                   inst_valid,
  output logic [WORD_LENGTH-1:0] instruction,
`ifdef IMEM_RANGE_CHECK_EN
  output logic                   addr_error,
`endif
  output logic [1:0]             dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [AW-1:0]          idx_q;
  logic [WORD_LENGTH-1:0] mem [DEPTH];

  logic [AW-1:0]          req_idx;
  logic [AW-1:0]          load_idx;
  logic [AW-1:0]          rd_idx;
  logic [WORD_LENGTH-1:0] rd_word;
  logic                   load_we;

  // Handshake: fetch holds req (and address) high until served; stall is the
  // fetch freeze and drops only in the DONE cycle that carries inst_valid, so
  // the PC advances on the edge that ends DONE. A flush cancels everything in
  // flight and keeps stall high so fetch re-requests the branch target.
  assign stall = req && !(rst && (state == DONE) && !flush);

  assign dbg_state = state;
  assign req_idx   = address[AW+1:2];
  assign load_idx  = load_addr[AW+1:2];

`ifdef IMEM_RANGE_CHECK_EN
  logic oor_q;
  logic req_oor;
  logic load_oor;
  logic rd_oor;
  logic unused_bits;

  assign req_oor     = ({2'b00, address[31:2]} >= 32'(DEPTH));
  assign load_oor    = ({2'b00, load_addr[31:2]} >= 32'(DEPTH));
  assign load_we     = load_en && !load_oor;
  assign unused_bits = ^{address[1:0], load_addr[1:0]};

  always_comb begin
    rd_idx  = (state == BUSY) ? idx_q : req_idx;
    rd_oor  = (state == BUSY) ? oor_q : req_oor;
    rd_word = rd_oor ? '0 : mem[rd_idx];
  end
`else
  logic unused_bits;

  // Out-of-range indices wrap: only the low AW bits of the word index are used.
  assign load_we     = load_en;
  assign unused_bits = ^{address[31:AW+2], address[1:0],
                         load_addr[31:AW+2], load_addr[1:0]};

  always_comb begin
    rd_idx  = (state == BUSY) ? idx_q : req_idx;
    rd_word = mem[rd_idx];
  end
`endif

  // Storage is not reset; preload works even while the controller is in reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      idx_q       <= '0;
      inst_valid  <= 1'b0;
      instruction <= '0;
`ifdef IMEM_RANGE_CHECK_EN
      oor_q       <= 1'b0;
      addr_error  <= 1'b0;
`endif
    end else begin
      inst_valid <= 1'b0;
`ifdef IMEM_RANGE_CHECK_EN
      addr_error <= 1'b0;
`endif
      unique case (state)
        IDLE, DONE: begin
          if (flush || !req) begin
            state <= IDLE;
          end else begin
            idx_q <= req_idx;
`ifdef IMEM_RANGE_CHECK_EN
            oor_q <= req_oor;
`endif
            cnt   <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              // Single-cycle latency reads straight from the presented address.
              state       <= DONE;
              inst_valid  <= 1'b1;
              instruction <= rd_word;
`ifdef IMEM_RANGE_CHECK_EN
              addr_error  <= rd_oor;
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state       <= DONE;
              inst_valid  <= 1'b1;
              instruction <= rd_word;
`ifdef IMEM_RANGE_CHECK_EN
              addr_error  <= rd_oor;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (LATENCY=2, DEPTH=256); optional
// IMEM_RANGE_CHECK_EN changes the expected range-test results.

module tb_imem_fetch_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] address;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        stall;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [1:0]  dbg_state;
`ifdef IMEM_RANGE_CHECK_EN
  logic        addr_error;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch_responder #(
    .WORD_LENGTH(32),
    .DEPTH      (256),
    .LATENCY    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .address    (address),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .stall      (stall),
    .inst_valid (inst_valid),
    .instruction(instruction),
`ifdef IMEM_RANGE_CHECK_EN
    .addr_error (addr_error),
`endif
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] word);
    load_en   = 1'b1;
    load_addr = byte_addr;
    load_data = word;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [31:0] W0  = 32'hA000_0000;
  localparam logic [31:0] W1  = 32'hA111_1111;
  localparam logic [31:0] W2  = 32'hA222_2222;
  localparam logic [31:0] W3  = 32'hE3A0_1005;
  localparam logic [31:0] W4  = 32'hDEAD_0004;
  localparam logic [31:0] W6  = 32'h6666_0000;
  localparam logic [31:0] W6N = 32'h7777_0000;
  localparam logic [31:0] W10 = 32'hBBBB_000A;

  logic [31:0] b2b_words [3];

  initial begin
    b2b_words[0] = W0;
    b2b_words[1] = W1;
    b2b_words[2] = W2;
    rst       = 1'b0;
    req       = 1'b0;
    address   = 32'd0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = 32'd0;
    load_data = 32'd0;

    // preload during reset
    preload(32'd0,  W0);
    preload(32'd4,  W1);
    preload(32'd8,  W2);
    preload(32'd12, W3);
    preload(32'd16, W4);
    preload(32'd24, W6);
    preload(32'd40, W10);

    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
`ifdef IMEM_RANGE_CHECK_EN
    check("rst_addr_err", 64'(addr_error), 64'd0);
`endif
    req = 1'b1;
    #1;
    check("rst_stall_eq_req", 64'(stall), 64'd1);
    req = 1'b0;
    #1;
    check("rst_stall_low", 64'(stall), 64'd0);

    rst = 1'b1;
    tick();

    // basic read of word 3
    req     = 1'b1;
    address = 32'd12;
    #1;
    check("basic_stall_c1", 64'(stall), 64'd1);
    tick();
    check("basic_state_busy", 64'(dbg_state), 64'd1);
    check("basic_stall_c2", 64'(stall), 64'd1);
    check("basic_valid_c2", 64'(inst_valid), 64'd0);
    tick();
    check("basic_valid", 64'(inst_valid), 64'd1);
    check("basic_instr", 64'(instruction), 64'(W3));
    check("basic_stall_done", 64'(stall), 64'd0);
    req = 1'b0;
    tick();
    check("basic_back_idle", 64'(dbg_state), 64'd0);
    check("basic_valid_once", 64'(inst_valid), 64'd0);

    // back-to-back fetches 0, 4, 8
    req     = 1'b1;
    address = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_busy_valid", 64'(inst_valid), 64'd0);
      check("b2b_busy_stall", 64'(stall), 64'd1);
      tick();
      check("b2b_valid", 64'(inst_valid), 64'd1);
      check("b2b_instr", 64'(instruction), 64'(b2b_words[i]));
      check("b2b_stall", 64'(stall), 64'd0);
      if (i < 2) address = 32'((i + 1) * 4);
      else req = 1'b0;
    end
    tick();
    check("b2b_idle", 64'(dbg_state), 64'd0);

    // flush while BUSY on word 4, redirect to word 10
    req     = 1'b1;
    address = 32'd16;
    tick();
    flush   = 1'b1;
    address = 32'd40;
    #1;
    check("flush_stall", 64'(stall), 64'd1);
    tick();
    flush = 1'b0;
    check("flush_no_valid", 64'(inst_valid), 64'd0);
    check("flush_idle", 64'(dbg_state), 64'd0);
    tick();
    check("flush_reaccept_valid", 64'(inst_valid), 64'd0);
    tick();
    check("flush_target_valid", 64'(inst_valid), 64'd1);
    check("flush_target_instr", 64'(instruction), 64'(W10));
    req = 1'b0;
    tick();

    // reset during BUSY
    req     = 1'b1;
    address = 32'd12;
    tick();
    check("midrst_busy", 64'(dbg_state), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_stall_eq_req", 64'(stall), 64'd1);
    tick();
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_valid", 64'(inst_valid), 64'd0);
    check("midrst_instr", 64'(instruction), 64'd0);
    rst = 1'b1;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_late", 64'(inst_valid), 64'd0);
    end

    // load one cycle before the request
    preload(32'd20, 32'h1234_5678);
    req     = 1'b1;
    address = 32'd20;
    tick();
    tick();
    check("load_valid", 64'(inst_valid), 64'd1);
    check("load_instr", 64'(instruction), 64'h1234_5678);
    req = 1'b0;
    tick();

    // write and read of word 6 on the same edge returns the old word
    req     = 1'b1;
    address = 32'd24;
    tick();
    load_en   = 1'b1;
    load_addr = 32'd24;
    load_data = W6N;
    tick();
    load_en = 1'b0;
    check("same_edge_valid", 64'(inst_valid), 64'd1);
    check("same_edge_old", 64'(instruction), 64'(W6));
    tick();
    tick();
    check("after_write_new", 64'(instruction), 64'(W6N));
    req = 1'b0;
    tick();

    // word index 256
    req     = 1'b1;
    address = 32'h400;
    tick();
    tick();
    check("range_valid", 64'(inst_valid), 64'd1);
`ifdef IMEM_RANGE_CHECK_EN
    check("range_instr_zero", 64'(instruction), 64'd0);
    check("range_addr_err", 64'(addr_error), 64'd1);
`else
    check("range_wrap_instr", 64'(instruction), 64'(W0));
`endif
    req = 1'b0;
    tick();
`ifdef IMEM_RANGE_CHECK_EN
    check("range_err_clear", 64'(addr_error), 64'd0);
`endif
    check("range_valid_clear", 64'(inst_valid), 64'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Multi-cycle instruction-memory responder serving the fetch stage: accepts a fetch address, returns the addressed word after a fixed number of wait states, and drives the stall that the fetch stage uses as its `freeze`. It replaces a zero-latency combinational instruction memory with a handshake, so fetch timing can model real memory latency. A load port preloads program words.

## Interface

Parameters:
- `WORD_LENGTH`, 32, instruction/data width.
- `DEPTH`, 256, number of words stored.
- `LATENCY`, 2, cycles from request acceptance to `inst_valid`; legal range 1..15.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, reset; synchronous, active-low.
- `req`, in, 1, fetch request; held high by fetch until served.
- `address`, in, 32, byte address; `address[1:0]` ignored, word index `address[31:2]`.
- `flush`, in, 1, branch taken; cancels any outstanding request.
- `load_en`, in, 1, write `load_data` into memory this cycle.
- `load_addr`, in, 32, byte address for load; `[1:0]` ignored.
- `load_data`, in, `WORD_LENGTH`, word to write.
- `stall`, out, 1, combinational; high while `req` is pending and not yet served; drives fetch `freeze`.
- `inst_valid`, out, 1, registered; high for one cycle with the returned word.
- `instruction`, out, `WORD_LENGTH`, registered; returned word.
- `addr_error`, out, 1, registered; present only with the range check macro.

## Operation

- States: IDLE, BUSY, DONE. Cycle counter `cnt` of 4 bits.
- IDLE: if `req && !flush`, latch word index, `cnt <= LATENCY-1`; go DONE if `LATENCY==1`, else BUSY. Otherwise stay.
- BUSY: `cnt` decrements each cycle; when `cnt==1`, read memory at the latched index into `instruction` and go DONE.
- DONE: `inst_valid=1` for this cycle. If `req && !flush`, accept the next address the same way as IDLE, giving back-to-back service. Otherwise go IDLE.
- `stall = req && !(state==DONE && !flush)`.
- `flush` in any state: forces the next state to IDLE, suppresses `inst_valid`, and no new request is accepted that cycle. `stall` stays high while `req` is high, so fetch re-requests the branch target next cycle.
- Load: `load_en` writes on any cycle regardless of state. The read is sampled on the transition into DONE, so a write in an earlier cycle is visible. A same-edge write and read to the same word returns the old word.
- Word index ≥ `DEPTH`: behaviour depends on the macro (see Configuration).

## Timing

- Reset (`rst==0` at an edge): state IDLE, `cnt=0`, `inst_valid=0`, `instruction=0`, `addr_error=0`. Memory contents are not reset. While in reset, `stall` equals `req`.
- Request accepted at edge T (state IDLE): `inst_valid` is high during cycle T+`LATENCY`.
- `stall` is high from `req` assertion through cycle T+`LATENCY`-1 and low in the DONE cycle, so the fetch PC advances on the edge ending DONE.
- Sustained throughput: one word per `LATENCY` cycles. With `LATENCY==1`: one word per cycle after the first.
- Reset asserted mid-request: the request is discarded and no `inst_valid` is produced.

## Configuration

- Macro `IMEM_RANGE_CHECK_EN`.
- Defined: word index ≥ `DEPTH` returns `instruction=0`. `addr_error=1` in the same cycle as `inst_valid`, otherwise 0.
- Undefined: the index wraps modulo `DEPTH` (low `$clog2(DEPTH)` bits). The `addr_error` port and its logic are absent.

## Test plan

All scenarios use `LATENCY=2`, `DEPTH=256`.
- Reset and basic read: preload word 3 = 32'hE3A01005; release reset; `req=1`, `address=12`. Required: `stall` high for 2 cycles, `inst_valid` high on the 2nd edge after acceptance with 32'hE3A01005, and `stall` low in that cycle.
- Back-to-back: addresses 0, 4, 8 presented as fetch advances. Required: `inst_valid` every 2nd cycle, words returned in order, no gaps beyond the latency.
- Flush in BUSY: accept `address=16`, assert `flush` the next cycle with `address=40`. Required: no `inst_valid` for word 4; `inst_valid` with word 10 exactly 2 cycles after the post-flush acceptance.
- Reset mid-request: `rst=0` during BUSY. Required: state IDLE, `inst_valid=0`, `instruction=0` after the edge, with no late response.
- Load coherence: write word 5 = 32'h12345678 one cycle before requesting `address=20`. Required: returns 32'h12345678.
- Range: `address=32'h400`. With `IMEM_RANGE_CHECK_EN`: `instruction=0`, `addr_error=1`. Without it: returns word 0.
